// File: rtl/jtag_host_driver.sv
// Command-driven JTAG host: walks a TAP through IR/DR scans or a TAP reset,
// driving registered TMS/TDI and capturing TDO, while mirroring the TAP state.
module jtag_host_driver #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_reset,
    input  logic               cmd_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_V   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RESET_ONES  = LEN_W'(5);

    // Collapsed TAP view: Pause/Exit2 are never requested by this host.
    typedef enum logic [2:0] {
        TS_TLR,
        TS_RTI,
        TS_SEL_DR,
        TS_SEL_IR,
        TS_CAPTURE,
        TS_SHIFT,
        TS_EXIT1,
        TS_UPDATE
    } tap_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_RUN,
        PH_ZERO
    } phase_e;

    tap_e               mirror_q, mirror_d;
    phase_e             phase_q, phase_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               rst_cmd_q, rst_cmd_d;
    logic               ir_q, ir_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] acc_q, acc_d;

    logic               accept;
    logic               shifting;
    logic [LEN_W-1:0]   len_clamp;
    logic [IDX_W-1:0]   bit_sel;

    function automatic tap_e tap_next(input tap_e s, input logic t);
        tap_e n;
        n = s;
        case (s)
            TS_TLR:     n = t ? TS_TLR    : TS_RTI;
            TS_RTI:     n = t ? TS_SEL_DR : TS_RTI;
            TS_SEL_DR:  n = t ? TS_SEL_IR : TS_CAPTURE;
            TS_SEL_IR:  n = t ? TS_TLR    : TS_CAPTURE;
            TS_CAPTURE: n = t ? TS_EXIT1  : TS_SHIFT;
            TS_SHIFT:   n = t ? TS_EXIT1  : TS_SHIFT;
            TS_EXIT1:   n = t ? TS_UPDATE : TS_EXIT1;
            TS_UPDATE:  n = t ? TS_SEL_DR : TS_RTI;
            default:    n = TS_TLR;
        endcase
        return n;
    endfunction

    always_comb begin
        // The TAP consumes the tms registered last edge, exactly as the mirror does.
        mirror_d    = tap_next(mirror_q, tms_q);
        phase_d     = phase_q;
        tms_d       = 1'b0;
        tdi_d       = 1'b0;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rst_cmd_d   = rst_cmd_q;
        ir_d        = ir_q;
        len_d       = len_q;
        idx_d       = idx_q;
        data_d      = data_q;
        acc_d       = acc_q;

        accept    = cmd_valid && cmd_ready_q;
        len_clamp = (cmd_len > MAX_LEN_V) ? MAX_LEN_V : cmd_len;
        shifting  = (phase_q == PH_RUN) && !rst_cmd_q && (mirror_q == TS_SHIFT);
        bit_sel   = idx_q[IDX_W-1:0];

        if (shifting) begin
            acc_d[bit_sel] = tdo;
            data_d         = data_q >> 1;
            idx_d          = idx_q + LEN_W'(1);
        end

        case (phase_q)
            PH_IDLE: begin
                if (accept) begin
                    rst_cmd_d = cmd_reset;
                    ir_d      = cmd_ir;
                    len_d     = len_clamp;
                    data_d    = cmd_data;
                    acc_d     = '0;
                    idx_d     = '0;
                    if (!cmd_reset && (len_clamp == '0)) begin
                        phase_d = PH_ZERO;
                    end else begin
                        phase_d = PH_RUN;
                        tms_d   = 1'b1;
                    end
                end
            end
            PH_ZERO: begin
                phase_d     = PH_IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = acc_q;
            end
            PH_RUN: begin
                if (mirror_d == TS_RTI) begin
                    phase_d     = PH_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = acc_q;
                end else if (rst_cmd_q) begin
                    // Five ones reach Test-Logic-Reset from anywhere, then a zero to idle.
                    idx_d = idx_q + LEN_W'(1);
                    tms_d = (idx_d < RESET_ONES);
                end else begin
                    // tms is chosen for the state the TAP will be in when it uses it.
                    case (mirror_d)
                        TS_SEL_DR: tms_d = ir_q;
                        TS_SHIFT: begin
                            tms_d = (idx_d == (len_q - LEN_W'(1)));
                            tdi_d = data_d[0];
                        end
                        TS_EXIT1:  tms_d = 1'b1;
                        default:   tms_d = 1'b0;
                    endcase
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        cmd_ready_d = (phase_d == PH_IDLE) && (mirror_d == TS_RTI);
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            mirror_q    <= TS_TLR;
            phase_q     <= PH_IDLE;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rst_cmd_q   <= 1'b0;
            ir_q        <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
        end else begin
            mirror_q    <= mirror_d;
            phase_q     <= phase_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rst_cmd_q   <= rst_cmd_d;
            ir_q        <= ir_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
        end
    end

    // Shift data and capture accumulator are cleared on acceptance, not by reset.
    always_ff @(posedge tck) begin
        data_q <= data_d;
        acc_q  <= acc_d;
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver with a 16-state TAP model holding an
// 8-bit IR (captures 0x01) and a BYPASS register (captures 0).
module tb_jtag_host_driver;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;

    localparam logic [3:0] S_TLR  = 4'd0,  S_RTI  = 4'd1,  S_SDR  = 4'd2,  S_CDR  = 4'd3;
    localparam logic [3:0] S_SHDR = 4'd4,  S_E1DR = 4'd5,  S_PDR  = 4'd6,  S_E2DR = 4'd7;
    localparam logic [3:0] S_UDR  = 4'd8,  S_SIR  = 4'd9,  S_CIR  = 4'd10, S_SHIR = 4'd11;
    localparam logic [3:0] S_E1IR = 4'd12, S_PIR  = 4'd13, S_E2IR = 4'd14, S_UIR  = 4'd15;

    logic               tck;
    logic               trst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_reset;
    logic               cmd_ir;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tms;
    logic               tdi;
    logic               tdo;

    jtag_host_driver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .tck      (tck),
        .trst     (trst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_reset(cmd_reset),
        .cmd_ir   (cmd_ir),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .tms      (tms),
        .tdi      (tdi),
        .tdo      (tdo)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // TAP model
    logic [3:0] ts;
    logic [7:0] ir;
    logic [7:0] ir_sr;
    logic       byp;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
        case (s)
            S_TLR:   return t ? S_TLR  : S_RTI;
            S_RTI:   return t ? S_SDR  : S_RTI;
            S_SDR:   return t ? S_SIR  : S_CDR;
            S_CDR:   return t ? S_E1DR : S_SHDR;
            S_SHDR:  return t ? S_E1DR : S_SHDR;
            S_E1DR:  return t ? S_UDR  : S_PDR;
            S_PDR:   return t ? S_E2DR : S_PDR;
            S_E2DR:  return t ? S_UDR  : S_SHDR;
            S_UDR:   return t ? S_SDR  : S_RTI;
            S_SIR:   return t ? S_TLR  : S_CIR;
            S_CIR:   return t ? S_E1IR : S_SHIR;
            S_SHIR:  return t ? S_E1IR : S_SHIR;
            S_E1IR:  return t ? S_UIR  : S_PIR;
            S_PIR:   return t ? S_E2IR : S_PIR;
            S_E2IR:  return t ? S_UIR  : S_SHIR;
            default: return t ? S_SDR  : S_RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        if (trst) begin
            ts <= S_TLR;
            ir <= 8'h01;
        end else begin
            ts <= tap_next(ts, tms);
            case (ts)
                S_TLR:  ir    <= 8'h01;
                S_CDR:  byp   <= 1'b0;
                S_SHDR: byp   <= tdi;
                S_CIR:  ir_sr <= 8'h01;
                S_SHIR: ir_sr <= {tdi, ir_sr[7:1]};
                S_UIR:  ir    <= ir_sr;
                default: ;
            endcase
        end
    end

    assign tdo = (ts == S_SHIR) ? ir_sr[0] : (ts == S_SHDR) ? byp : 1'b0;

    int tests = 0;
    int fails = 0;

    logic [127:0]       tr;
    int                 at;
    logic [MAX_LEN-1:0] rd;
    int                 ready_early;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    // Offers a command and takes edge A; tr[0] holds tms registered at A.
    task automatic issue(input logic rst_c, input logic ir_c, input logic [LEN_W-1:0] len_c,
                         input logic [MAX_LEN-1:0] data_c, input logic hold);
        check("ready_before_cmd", {127'd0, cmd_ready}, 128'd1);
        cmd_reset = rst_c;
        cmd_ir    = ir_c;
        cmd_len   = len_c;
        cmd_data  = data_c;
        cmd_valid = 1'b1;
        step();
        check("ready_drop_on_accept", {127'd0, cmd_ready}, 128'd0);
        tr    = '0;
        tr[0] = tms;
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_reset = ~rst_c;
            cmd_ir    = ~ir_c;
            cmd_len   = 7'd3;
            cmd_data  = ~data_c;
        end
    endtask

    // Records tms per edge until rsp_valid; at = edge offset from the last step, -1 on timeout.
    task automatic wait_rsp(input int limit);
        at          = -1;
        rd          = '0;
        ready_early = 0;
        for (int k = 1; k <= limit; k++) begin
            step();
            tr[k] = tms;
            if (rsp_valid) begin
                at = k;
                rd = rsp_data;
                break;
            end
            if (cmd_ready) ready_early++;
        end
    endtask

    task automatic finish_pulse();
        step();
        check("rsp_valid_single_pulse", {127'd0, rsp_valid}, 128'd0);
        check("tap_model_in_rti", {124'd0, ts}, {124'd0, S_RTI});
    endtask

    initial begin
        int pulses;
        int ready_at;
        trst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_reset = 1'b0;
        cmd_ir    = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;

        // Reset release
        step();
        step();
        step();
        check("reset_tms", {127'd0, tms}, 128'd1);
        check("reset_tdi", {127'd0, tdi}, 128'd0);
        check("reset_ready", {127'd0, cmd_ready}, 128'd0);
        check("reset_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        check("reset_rsp_data", {64'd0, rsp_data}, 128'd0);
        trst = 1'b0;
        step();
        check("release_e1_tms", {127'd0, tms}, 128'd0);
        check("release_e1_ready", {127'd0, cmd_ready}, 128'd0);
        step();
        check("release_e2_ready", {127'd0, cmd_ready}, 128'd1);

        // DR scan through BYPASS
        issue(1'b0, 1'b0, 7'd8, 64'hA5, 1'b0);
        wait_rsp(100);
        check("dr8_rsp_edge", at, 13);
        check("dr8_rsp_data", {64'd0, rd}, 128'h4A);
        check("dr8_tms_trace", tr, 128'hC01);
        check("dr8_ready_held_low", ready_early, 0);
        check("dr8_ready_with_rsp", {127'd0, cmd_ready}, 128'd1);
        finish_pulse();

        // IR scan
        issue(1'b0, 1'b1, 7'd8, 64'h3C, 1'b0);
        wait_rsp(100);
        check("ir8_rsp_edge", at, 14);
        check("ir8_rsp_data", {64'd0, rd}, 128'h01);
        check("ir8_tms_trace", tr, 128'h1803);
        check("ir8_model_ir", {120'd0, ir}, 128'h3C);
        finish_pulse();
        check("ir8_rsp_data_holds", {64'd0, rsp_data}, 128'h01);

        // Reset command
        issue(1'b1, 1'b0, 7'd20, 64'hFFFF_FFFF, 1'b0);
        wait_rsp(100);
        check("rstcmd_rsp_edge", at, 6);
        check("rstcmd_rsp_data", {64'd0, rd}, 128'd0);
        check("rstcmd_tms_trace", tr, 128'h1F);
        finish_pulse();

        // Zero length
        issue(1'b0, 1'b0, 7'd0, 64'h1234, 1'b0);
        wait_rsp(100);
        check("len0_rsp_edge", at, 1);
        check("len0_rsp_data", {64'd0, rd}, 128'd0);
        check("len0_tms_trace", tr, 128'd0);
        finish_pulse();

        // Over-length clamps to 64
        issue(1'b0, 1'b0, 7'd100, 64'hDEAD_BEEF_0123_4567, 1'b0);
        wait_rsp(200);
        check("len100_rsp_edge", at, 69);
        check("len100_rsp_data", {64'd0, rd}, 128'hBD5B_7DDE_0246_8ACE);
        check("len100_tms_trace", tr, (128'd3 << 66) | 128'd1);
        finish_pulse();

        // Abort at A+6 of a 32-bit DR scan
        issue(1'b0, 1'b0, 7'd32, 64'h1234_5678, 1'b0);
        for (int k = 1; k <= 5; k++) step();
        trst = 1'b1;
        step();
        check("abort_tms", {127'd0, tms}, 128'd1);
        check("abort_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        check("abort_ready", {127'd0, cmd_ready}, 128'd0);
        check("abort_rsp_data", {64'd0, rsp_data}, 128'd0);
        trst     = 1'b0;
        pulses   = 0;
        ready_at = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (rsp_valid) pulses++;
            if (cmd_ready && ready_at < 0) ready_at = k;
        end
        check("abort_no_rsp", pulses, 0);
        check("abort_recover_ready_edge", ready_at, 2);

        // Back-to-back: second command held valid through the first
        issue(1'b0, 1'b0, 7'd8, 64'hA5, 1'b1);
        cmd_len  = 7'd4;
        cmd_data = 64'h9;
        wait_rsp(100);
        check("b2b_first_rsp_edge", at, 13);
        check("b2b_first_rsp_data", {64'd0, rd}, 128'h4A);
        step();
        check("b2b_second_accepted", {127'd0, cmd_ready}, 128'd0);
        check("b2b_pulse_end", {127'd0, rsp_valid}, 128'd0);
        cmd_valid = 1'b0;
        cmd_data  = 64'hFFFF;
        cmd_len   = 7'd50;
        tr        = '0;
        wait_rsp(100);
        check("b2b_second_rsp_edge", at, 9);
        check("b2b_second_rsp_data", {64'd0, rd}, 128'h2);
        finish_pulse();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jtag_host_driver.md
# jtag_host_driver

Command-driven JTAG host that produces TMS/TDI and samples TDO to walk a TAP through IR and DR scans. It is the initiator end of the TAP interface: its tms/tdi outputs feed the TAP's inputs and the TAP's tdo returns here. It is clocked by the same tck as the TAP. It keeps an internal mirror of the TAP state, so after every edge the mirror equals the TAP FSM state.

## Interface
- MAX_LEN, 64: maximum scan length in bits.
- LEN_W, $clog2(MAX_LEN+1): width of cmd_len.
- tck  in  1  test clock, shared with the TAP.
- trst  in  1  reset. Synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  driver idle in Run-Test/Idle and able to accept a command.
- cmd_reset  in  1  command is a TAP reset; overrides cmd_ir, cmd_len and cmd_data.
- cmd_ir  in  1  1 selects an IR scan, 0 selects a DR scan.
- cmd_len  in  LEN_W  number of bits to shift.
- cmd_data  in  MAX_LEN  shift-in data, LSB first.
- rsp_valid  out  1  single-cycle pulse when a command completes.
- rsp_data  out  MAX_LEN  captured TDO bits, LSB first; bits at positions >= len are 0.
- tms  out  1  registered TMS to the TAP.
- tdi  out  1  registered TDI to the TAP.
- tdo  in  1  TDO from the TAP.

## Operation
- **Output rule:**
  - tms/tdi are registered at edge k and used by the TAP at edge k+1.
  - Outputs are therefore computed from the mirror's next state.
- **Command acceptance:** a command is accepted on an edge with cmd_valid && cmd_ready. cmd_ready drops on that same edge.
- **Mirror states:** TLR, RTI, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE. The IR/DR flavour is held in a flag.
- **TMS sequences**, starting from RTI:
  - DR scan: 1, 0, 0, then N shift bits with tms=0 except the last bit (tms=1), then 1, 0.
  - IR scan: 1, 1, 0, 0, shift bits as for DR, then 1, 0.
  - Reset: 1,1,1,1,1, then 0.
- **TDI:** carries cmd_data[i] while shifting bit i. It is 0 at all other times.
- **TDO capture:**
  - tdo is sampled on each edge where the TAP is in Shift and shifts a bit.
  - The sample is stored into rsp_data[i], where i is the index of the bit being shifted at that edge.
  - Bits not shifted in the current command read 0.
- **Length rules:**
  - cmd_len=0: no TMS activity. rsp_valid pulses on the edge after acceptance with rsp_data=0.
  - cmd_len>MAX_LEN: clamped to MAX_LEN.
- **Command data:** cmd_data is latched on acceptance. Later changes on the cmd_* inputs have no effect on the running command.
- **Response:**
  - No backpressure; rsp_valid is a 1-cycle pulse.
  - cmd_ready rises on the same edge as rsp_valid, so a back-to-back command can be accepted on the next edge.
  - rsp_data holds its value until the next command completes.
- **Reset mid-command:** trst aborts the command at once. All outputs return to their reset values and no rsp_valid is issued.

## Timing
- **Reset values:** tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0. Mirror state = TLR.
- **After trst deasserts:**
  - First edge registers tms=0.
  - Second edge: mirror = RTI and cmd_ready=1.
- Command accepted at edge A, N = effective length (N ≥ 1 for scans):
- **DR scan:**
  - Output edges A..A+N+4.
  - Bit i is shifted and sampled at edge A+4+i.
  - rsp_valid and cmd_ready at edge A+N+5, when the TAP is back in RTI.
- **IR scan:**
  - Everything is one edge later than DR.
  - Bit i is sampled at edge A+5+i.
  - rsp_valid at edge A+N+6.
- **Reset command:**
  - tms=1 at edges A..A+4 and tms=0 at A+5.
  - rsp_valid at edge A+6 with rsp_data=0.
- **Throughput:** one command in flight at a time.

## Test plan
- **Reset release:**
  - Stimulus: trst high for 3 cycles, then low.
  - Required: tms=1 and cmd_ready=0 during reset; tms=0 at edge 1; cmd_ready=1 at edge 2 after release.
- **DR scan through a BYPASS bench model** (1-bit register, captures 0):
  - Stimulus: cmd_len=8, cmd_data=0xA5.
  - Required: rsp_data=0x4A.
  - Required TMS trace: 1,0,0,0,0,0,0,0,0,0,1,1,0.
  - Required: rsp_valid at A+13.
- **IR scan into a bench 8-bit IR model** that captures 0x01:
  - Stimulus: cmd_ir=1, cmd_len=8, cmd_data=0x3C.
  - Required: rsp_data=0x01; model IR=0x3C after Update-IR; rsp_valid at A+14.
- **Reset command:**
  - Stimulus: cmd_reset=1 with cmd_len=20.
  - Required: tms=1 for 5 edges then 0; model TAP ends in RTI; rsp_valid at A+6; rsp_data=0.
- **Length edge cases:**
  - cmd_len=0 → rsp_valid at A+1, tms stays 0.
  - cmd_len=100 → treated as 64 bits, rsp_valid at A+69.
- **Abort and back-to-back:**
  - Stimulus: trst asserted at A+6 of a 32-bit DR scan.
  - Required: no rsp_valid; tms=1 on the next edge; normal recovery afterwards.
  - Stimulus: a second command held valid during the first.
  - Required: it is accepted on the edge after the first rsp_valid.
